// File: rtl/hdu_pkg.sv
// Shared types and default widths for the hazard scoreboard unit.
// - reg_idx_t     : architectural register index
// - flush_state_t : branch-flush FSM states
// - *_DEF         : default sizing constants, including the clog2-derived
//                   scoreboard/occupancy counter width
package hdu_pkg;

    localparam int NUM_REGS_DEF  = 32;
    localparam int REG_W_DEF     = 5;
    localparam int MAX_LOADS_DEF = 2;
    localparam int CNT_W_DEF     = $clog2(MAX_LOADS_DEF + 1);
    localparam int FL_CNT_W      = 2;   // holds BR_PENALTY-1 for BR_PENALTY up to 3

    typedef logic [REG_W_DEF-1:0] reg_idx_t;

    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_FLUSH = 1'b1
    } flush_state_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle between the ID stage / data memory and the hazard scoreboard unit.
// master : pipeline side; drives ID-stage fields, branch and memory response,
//          and receives the enables, flush and status outputs.
// slave  : the hazard scoreboard unit itself.
interface hazard_scoreboard_unit_if
    import hdu_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_memread;
    logic             branch_taken_ID;
    logic             mem_rsp_valid;
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             Stall;
    logic             IF_ID_Flush;
    logic [CNT_W-1:0] loads_outstanding;
    logic [31:0]      stall_cycles;
    logic             rsp_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_memread, branch_taken_ID, mem_rsp_valid,
        input  PCWrite, IF_ID_Write, Stall, IF_ID_Flush, loads_outstanding,
               stall_cycles, rsp_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_memread, branch_taken_ID, mem_rsp_valid,
        output PCWrite, IF_ID_Write, Stall, IF_ID_Flush, loads_outstanding,
               stall_cycles, rsp_err
    );

endinterface

// File: rtl/hdu_load_fifo.sv
// In-order FIFO of destination register indices for outstanding loads.
// Ports: clk, reset (sync, active-high), push/din, pop, head (oldest entry),
//        full, empty, count (occupancy).
// A push while full is accepted only when a pop happens in the same cycle.
module hdu_load_fifo
    import hdu_pkg::*;
#(
    parameter int DEPTH = MAX_LOADS_DEF,
    parameter int W     = REG_W_DEF,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Entry storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-scoreboard hazard unit for the 5-stage pipeline.
// Ports: clk, reset (sync, active-high), bus (slave modport) carrying the ID
// fields, branch and memory response in; PCWrite/IF_ID_Write/Stall/IF_ID_Flush
// (combinational), loads_outstanding, stall_cycles and sticky rsp_err out.
// Each register keeps a count of in-flight loads targeting it; loads retire
// strictly in order through hdu_load_fifo.
module hazard_scoreboard_unit
    import hdu_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int REG_W      = REG_W_DEF,
    parameter int MAX_LOADS  = MAX_LOADS_DEF,
    parameter int BR_PENALTY = 1,
    parameter int RSP_BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_scoreboard_unit_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LOADS + 1);

    logic [CNT_W-1:0]    cnt_r [NUM_REGS];
    logic [REG_W-1:0]    head_s;
    logic                full_s;
    logic                empty_s;
    logic [CNT_W-1:0]    count_s;
    flush_state_t        state_r, state_s;
    logic [FL_CNT_W-1:0] fl_cnt_r, fl_cnt_s;
    logic [31:0]         stall_cycles_r;
    logic                rsp_err_r;
    logic                pop_s, push_s, issue_s, accept_br_s, flushing_s;
    logic                pm1_s, pm2_s, busy1_s, busy2_s;
    logic                hz_data_s, hz_full_s, stall_s;

    hdu_load_fifo #(.DEPTH(MAX_LOADS), .W(REG_W), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (bus.id_rd),
        .pop   (pop_s),
        .head  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign pop_s      = bus.mem_rsp_valid & ~empty_s;
    assign flushing_s = (fl_cnt_r != {FL_CNT_W{1'b0}});

    // With bypass, the load retiring this cycle no longer counts as busy.
    assign pm1_s   = (RSP_BYPASS != 0) & pop_s & (head_s == bus.id_rs1);
    assign pm2_s   = (RSP_BYPASS != 0) & pop_s & (head_s == bus.id_rs2);
    assign busy1_s = (bus.id_rs1 != {REG_W{1'b0}}) &
                     ((cnt_r[bus.id_rs1] - CNT_W'(pm1_s)) != {CNT_W{1'b0}});
    assign busy2_s = (bus.id_rs2 != {REG_W{1'b0}}) &
                     ((cnt_r[bus.id_rs2] - CNT_W'(pm2_s)) != {CNT_W{1'b0}});

    assign hz_data_s = bus.id_valid & ((bus.id_rs1_used & busy1_s) |
                                       (bus.id_rs2_used & busy2_s));
    // A same-cycle response frees a slot, so a full FIFO only blocks without one.
    assign hz_full_s = bus.id_valid & bus.id_memread & full_s & ~bus.mem_rsp_valid;
    assign stall_s   = (hz_data_s | hz_full_s) & ~flushing_s & ~reset;

    assign issue_s     = bus.id_valid & ~stall_s & ~flushing_s & ~reset;
    assign push_s      = issue_s & bus.id_memread;
    assign accept_br_s = issue_s & bus.branch_taken_ID;

    assign bus.Stall             = stall_s;
    assign bus.PCWrite           = ~stall_s;
    assign bus.IF_ID_Write       = ~stall_s;
    assign bus.IF_ID_Flush       = (accept_br_s | flushing_s) & ~reset;
    assign bus.loads_outstanding = count_s;
    assign bus.stall_cycles      = stall_cycles_r;
    assign bus.rsp_err           = rsp_err_r;

    // Flush FSM next state: the first flush cycle is the accept cycle itself,
    // so the counter only covers the remaining BR_PENALTY-1 cycles.
    always_comb begin
        state_s  = state_r;
        fl_cnt_s = fl_cnt_r;
        case (state_r)
            FL_IDLE: begin
                if (accept_br_s && (BR_PENALTY > 1)) begin
                    state_s  = FL_FLUSH;
                    fl_cnt_s = FL_CNT_W'(BR_PENALTY - 1);
                end else begin
                    state_s  = FL_IDLE;
                end
            end
            FL_FLUSH: begin
                fl_cnt_s = fl_cnt_r - FL_CNT_W'(1);
                if (fl_cnt_r == FL_CNT_W'(1)) begin
                    state_s = FL_IDLE;
                end else begin
                    state_s = FL_FLUSH;
                end
            end
            default: begin
                state_s  = FL_IDLE;
                fl_cnt_s = {FL_CNT_W{1'b0}};
            end
        endcase
    end

    // Flush FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= FL_IDLE;
            fl_cnt_r <= {FL_CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            fl_cnt_r <= fl_cnt_s;
        end
    end

    // Per-register outstanding-load counts; x0 is never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_r[r] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (push_s && (bus.id_rd == REG_W'(r)) &&
                    !(pop_s && (head_s == REG_W'(r)))) begin
                    cnt_r[r] <= cnt_r[r] + CNT_W'(1);
                end else if (pop_s && (head_s == REG_W'(r)) &&
                             !(push_s && (bus.id_rd == REG_W'(r)))) begin
                    cnt_r[r] <= cnt_r[r] - CNT_W'(1);
                end
            end
        end
    end

    // Stall cycle counter (wraps) and sticky response-without-load error.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_r <= 32'd0;
            rsp_err_r      <= 1'b0;
        end else begin
            if (stall_s) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (bus.mem_rsp_valid && empty_s) begin
                rsp_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed scoreboard bench for hazard_scoreboard_unit (MAX_LOADS=2,
// BR_PENALTY=2, RSP_BYPASS=1). Each step drives one cycle of inputs and
// queues the hand-computed outputs expected in that cycle; a monitor on the
// falling edge pops and compares.
module tb_hazard_scoreboard_unit;
    import hdu_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        string       name;
        logic        stall;
        logic        flush;
        logic [31:0] lo;
        logic [31:0] sc;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    hazard_scoreboard_unit_if #(.REG_W(5), .CNT_W(2)) bus();

    hazard_scoreboard_unit #(
        .NUM_REGS   (32),
        .REG_W      (5),
        .MAX_LOADS  (2),
        .BR_PENALTY (2),
        .RSP_BYPASS (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, exp_v);
        end
    endtask

    // Monitor: compare the outputs of every cycle that has a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.name, "Stall",       {31'd0, bus.Stall},       {31'd0, e.stall});
            chk(e.name, "PCWrite",     {31'd0, bus.PCWrite},     {31'd0, ~e.stall});
            chk(e.name, "IF_ID_Write", {31'd0, bus.IF_ID_Write}, {31'd0, ~e.stall});
            chk(e.name, "IF_ID_Flush", {31'd0, bus.IF_ID_Flush}, {31'd0, e.flush});
            chk(e.name, "loads_out",   {30'd0, bus.loads_outstanding}, e.lo);
            chk(e.name, "stall_cycles", bus.stall_cycles, e.sc);
            chk(e.name, "rsp_err",     {31'd0, bus.rsp_err},     {31'd0, e.err});
        end
    end

    // One cycle: inputs (rst v rs1 rs2 u1 u2 rd mr br rsp), then expected
    // Stall, IF_ID_Flush, loads_outstanding, stall_cycles, rsp_err.
    task automatic step(input string nm, input logic rst, input logic v,
                        input int rs1, input int rs2, input logic u1, input logic u2,
                        input int rd, input logic mr, input logic br, input logic rsp,
                        input logic e_stall, input logic e_flush,
                        input int e_lo, input int e_sc, input logic e_err);
        exp_t e;
        reg_idx_t r1, r2, rdi;
        @(posedge clk);
        #1;
        r1  = reg_idx_t'(rs1);
        r2  = reg_idx_t'(rs2);
        rdi = reg_idx_t'(rd);
        reset               = rst;
        bus.id_valid        = v;
        bus.id_rs1          = r1;
        bus.id_rs2          = r2;
        bus.id_rs1_used     = u1;
        bus.id_rs2_used     = u2;
        bus.id_rd           = rdi;
        bus.id_memread      = mr;
        bus.branch_taken_ID = br;
        bus.mem_rsp_valid   = rsp;
        e.name  = nm;
        e.stall = e_stall;
        e.flush = e_flush;
        e.lo    = 32'(e_lo);
        e.sc    = 32'(e_sc);
        e.err   = e_err;
        exp_q.push_back(e);
    endtask

    initial begin
        reset               = 1'b1;
        bus.id_valid        = 1'b0;
        bus.id_rs1          = '0;
        bus.id_rs2          = '0;
        bus.id_rs1_used     = 1'b0;
        bus.id_rs2_used     = 1'b0;
        bus.id_rd           = '0;
        bus.id_memread      = 1'b0;
        bus.branch_taken_ID = 1'b0;
        bus.mem_rsp_valid   = 1'b0;
        repeat (2) @(posedge clk);

        //        name       rst v  rs1 rs2 u1 u2 rd mr br rsp  stall flush lo sc err
        step("rst_hold",     1, 1,  1,  3,  1, 1,  2, 1, 1, 0,  0, 0, 0, 0, 0);
        step("nohaz",        0, 1,  1,  3,  1, 1,  2, 0, 0, 0,  0, 0, 0, 0, 0);
        // load x1, dependent waits for response in cycle 4 (bypassed)
        step("lu_c0",        0, 1,  0,  0,  0, 0,  1, 1, 0, 0,  0, 0, 0, 0, 0);
        step("lu_c1",        0, 1,  1,  0,  1, 0,  2, 0, 0, 0,  1, 0, 1, 0, 0);
        step("lu_c2",        0, 1,  1,  0,  1, 0,  2, 0, 0, 0,  1, 0, 1, 1, 0);
        step("lu_c3",        0, 1,  1,  0,  1, 0,  2, 0, 0, 0,  1, 0, 1, 2, 0);
        step("lu_c4",        0, 1,  1,  0,  1, 0,  2, 0, 0, 1,  0, 0, 1, 3, 0);
        step("lu_c5",        0, 0,  0,  0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 3, 0);
        // two loads to x5
        step("dbl_c0",       0, 1,  0,  0,  0, 0,  5, 1, 0, 0,  0, 0, 0, 3, 0);
        step("dbl_c1",       0, 1,  0,  0,  0, 0,  5, 1, 0, 0,  0, 0, 1, 3, 0);
        step("dbl_rsp1",     0, 1,  5,  0,  1, 0,  2, 0, 0, 1,  1, 0, 2, 3, 0);
        step("dbl_wait",     0, 1,  5,  0,  1, 0,  2, 0, 0, 0,  1, 0, 1, 4, 0);
        step("dbl_rsp2",     0, 1,  5,  0,  1, 0,  2, 0, 0, 1,  0, 0, 1, 5, 0);
        step("dbl_idle",     0, 0,  0,  0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 5, 0);
        // taken branch, penalty 2; load during flush must not issue
        step("br_acc",       0, 1,  0,  0,  0, 0,  0, 0, 1, 0,  0, 1, 0, 5, 0);
        step("br_fl2",       0, 1,  0,  0,  0, 0,  9, 1, 1, 0,  0, 1, 0, 5, 0);
        step("br_done",      0, 0,  0,  0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 5, 0);
        // taken branch waiting on busy rs1
        step("brh_ld",       0, 1,  0,  0,  0, 0,  4, 1, 0, 0,  0, 0, 0, 5, 0);
        step("brh_wait",     0, 1,  4,  0,  1, 0,  0, 0, 1, 0,  1, 0, 1, 5, 0);
        step("brh_acc",      0, 1,  4,  0,  1, 0,  0, 0, 1, 1,  0, 1, 1, 6, 0);
        step("brh_fl2",      0, 1,  4,  0,  1, 0,  0, 0, 0, 0,  0, 1, 0, 6, 0);
        step("brh_done",     0, 0,  0,  0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 6, 0);
        // FIFO full
        step("full_ld6",     0, 1,  0,  0,  0, 0,  6, 1, 0, 0,  0, 0, 0, 6, 0);
        step("full_ld7",     0, 1,  0,  0,  0, 0,  7, 1, 0, 0,  0, 0, 1, 6, 0);
        step("full_stall",   0, 1,  0,  0,  0, 0,  8, 1, 0, 0,  1, 0, 2, 6, 0);
        step("full_rsp",     0, 1,  0,  0,  0, 0,  8, 1, 0, 1,  0, 0, 2, 7, 0);
        step("full_after",   0, 0,  0,  0,  0, 0,  0, 0, 0, 0,  0, 0, 2, 7, 0);
        // reset with x7, x8 outstanding
        step("rst_mid",      1, 1,  0,  0,  0, 0, 10, 1, 0, 0,  0, 0, 2, 7, 0);
        step("rst_rsp1",     0, 0,  0,  0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 0, 0);
        step("rst_rsp2",     0, 0,  0,  0,  0, 0,  0, 0, 0, 1,  0, 0, 0, 0, 1);
        step("rst_x7free",   0, 1,  7,  0,  1, 0,  2, 0, 0, 0,  0, 0, 0, 0, 1);
        step("err_sticky",   0, 0,  0,  0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1);
        step("rst_again",    1, 0,  0,  0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1);
        step("err_clear",    0, 0,  0,  0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        bus.id_valid      = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Next-generation hazard detection for the 5-stage RISC-V pipeline. It replaces the purely combinational load-use check with a per-register load scoreboard, so data memory may return load data with variable latency. It supports up to `MAX_LOADS` outstanding in-order loads and applies a parametrised branch-flush window. It sits beside the ID stage and drives PC/IF_ID enables, the ID/EX bubble and the IF/ID flush.

## Interface
Parameters:
- `NUM_REGS`, 32, architectural registers; x0 is never busy.
- `REG_W`, 5, register index width, equal to clog2(`NUM_REGS`).
- `MAX_LOADS`, 2, outstanding-load FIFO depth; power of two, at least 1.
- `BR_PENALTY`, 1, IF/ID flush cycles per taken branch; range 1..3.
- `RSP_BYPASS`, 1:
  - 1: a dependent may issue in the same cycle as the matching `mem_rsp_valid`.
  - 0: it issues the cycle after.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  `REG_W`  ID source registers.
- `id_rs1_used`, `id_rs2_used`  in  1  the source register is actually read.
- `id_rd`  in  `REG_W`  ID destination register.
- `id_memread`  in  1  the ID instruction is a load.
- `branch_taken_ID`  in  1  branch resolved taken in ID.
- `mem_rsp_valid`  in  1  the oldest outstanding load's data is returned this cycle.
- `PCWrite`  out  1  PC update enable.
- `IF_ID_Write`  out  1  IF/ID register enable.
- `Stall`  out  1  insert a bubble into ID/EX.
- `IF_ID_Flush`  out  1  zero the IF/ID register.
- `loads_outstanding`  out  clog2(`MAX_LOADS`+1)  current FIFO occupancy.
- `stall_cycles`  out  32  count of cycles with `Stall`=1; wraps at 2^32.
- `rsp_err`  out  1  sticky; set when a response arrives with the FIFO empty.

## Operation
- **Scoreboard:** `cnt[r]` is the number of outstanding loads targeting register r; its width is clog2(`MAX_LOADS`+1).
- **Effective busy:** `busy(r)` = r≠0 AND (`cnt[r]` − `pop_match(r)`) ≠ 0.
  - `pop_match(r)` = `RSP_BYPASS` AND `mem_rsp_valid` AND FIFO non-empty AND head.rd = r.
- **Data hazard:** `hz_data` = `id_valid` AND (a used source register is busy).
- **Structural hazard:** `hz_full` = `id_valid` AND `id_memread` AND FIFO full AND NOT `mem_rsp_valid`.
- **Stall condition:** `Stall` = (`hz_data` OR `hz_full`) AND NOT `flushing`.
  - While `Stall`=1, `PCWrite`=0 and `IF_ID_Write`=0; otherwise both are 1.
- **Issue:** issue = `id_valid` AND NOT `Stall` AND NOT `flushing`.
  - If the issuing instruction is a load, push `id_rd` into the FIFO. x0 is pushed too, to keep response ordering, but its `cnt` is never incremented.
- **Response:** `mem_rsp_valid` with the FIFO non-empty pops the head and decrements `cnt[head.rd]`.
  - A push and a pop of the same rd in one cycle leave `cnt` unchanged.
  - A response with the FIFO empty is ignored and sets `rsp_err`.
- **Branch:** `branch_taken_ID` acts only when `id_valid` is 1 and `Stall` is 0. A branch with a data hazard waits.
  - On acting, `IF_ID_Flush`=1 that cycle and a down-counter is loaded with `BR_PENALTY`−1.
  - `flushing` = (counter ≠ 0). While flushing, `IF_ID_Flush`=1, the ID contents are treated as a bubble and `branch_taken_ID` is ignored.
- **Flush FSM:** states IDLE and FLUSH.
  - IDLE→FLUSH on an accepted taken branch when `BR_PENALTY`>1.
  - FLUSH→IDLE when the counter reaches 0.
- **Reset:** FIFO emptied, all `cnt` cleared to 0, FSM to IDLE, `stall_cycles`=0, `rsp_err`=0.
  - While `reset` is high: `PCWrite`=1, `IF_ID_Write`=1, `Stall`=0, `IF_ID_Flush`=0.
  - Loads in flight at reset are forgotten. Their late responses set `rsp_err`.

## Timing
- `Stall`, `PCWrite`, `IF_ID_Write` and `IF_ID_Flush` are combinational from the inputs and registered state, with zero latency.
- A load issued in cycle N makes its rd busy from cycle N+1.
- A dependent of that load issues:
  - in the `mem_rsp_valid` cycle when `RSP_BYPASS`=1;
  - one cycle later when `RSP_BYPASS`=0.
- Scoreboard, FIFO, counter and `rsp_err` updates all take effect at the rising edge of `clk`.
- Responses are strictly in order and at most one per cycle.

## Structure
- Package `hdu_pkg`: `reg_idx_t` (`REG_W` bits), flush-FSM state enum {`FL_IDLE`, `FL_FLUSH`}, and the `clog2`-derived width constants.
- Sub-module `hdu_load_fifo`: `MAX_LOADS`-deep FIFO of rd indices. Ports: push, pop, head, full, empty, count. Synchronous reset.

## Test plan
- **No hazard:** `id_valid`=1, rs1=1, rs2=3, nothing outstanding → `PCWrite`=1, `IF_ID_Write`=1, `Stall`=0, `IF_ID_Flush`=0.
- **Load-use, variable latency:**
  - Stimulus: load x1 issues in cycle 0; ID holds rs1=x1 from cycle 1; `mem_rsp_valid` in cycle 4.
  - `RSP_BYPASS`=1 → `Stall`=1 in cycles 1-3, 0 in cycle 4; `stall_cycles`=3.
  - `RSP_BYPASS`=0 → `Stall`=1 in cycles 1-4.
- **Double load to x5:**
  - Two loads to x5 outstanding, first response → x5 still busy, `Stall` remains 1.
  - Second response → `cnt[5]`=0, `Stall`=0.
- **FIFO full, `MAX_LOADS`=2:**
  - Two loads outstanding, third load in ID with no response → `Stall`=1, `loads_outstanding`=2.
  - Same cycle with a response → load issues and `loads_outstanding` stays 2.
- **Branch, `BR_PENALTY`=2:**
  - Accepted taken branch → `IF_ID_Flush`=1 for 2 cycles.
  - Taken branch whose rs1 is busy → no flush until the cycle `Stall` falls.
- **Reset mid-operation:**
  - Stimulus: 2 loads outstanding, `reset` for 1 cycle.
  - Response → `loads_outstanding`=0, `Stall`=0, `stall_cycles`=0.
  - A subsequent `mem_rsp_valid` → `rsp_err`=1 and stays 1 until the next reset.
